regbank_arbiter: RTL and testbench
==================================

# regbank_arbiter

Arbitrates single-byte access to the shared register bank (REGCOUNT × 8 bits) between two requesters: the I2C slave port (bus-side reads and writes) and the on-chip core port (local logic). It drives the bank's write-enable, address and write-data, and returns registered read data. During an I2C transaction (START to STOP) it gives the I2C side exclusive ownership, and a watchdog flags core starvation.

## Interface
Parameters:
- REGCOUNT, 32, number of 8-bit registers in the bank.
- ADDR_W, 5, address width; REGCOUNT ≤ 2**ADDR_W.
- MAX_WAIT, 255, core wait cycles under lock before `core_starve` sets.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- i2c_req  in  1  I2C access request; level, held until `i2c_gnt`.
- i2c_we  in  1  1 = write, 0 = read.
- i2c_addr  in  ADDR_W  register index.
- i2c_wdata  in  8  write data.
- i2c_lock  in  1  high between START and STOP; blocks new core grants.
- i2c_gnt  out  1  one-cycle grant pulse.
- i2c_rvalid  out  1  one-cycle pulse; `i2c_rdata` valid.
- i2c_rdata  out  8  read data.
- core_req, core_we, core_addr, core_wdata  in  1/1/ADDR_W/8  same semantics as the I2C side.
- core_gnt, core_rvalid  out  1  same semantics as the I2C side.
- core_rdata  out  8  read data.
- core_starve  out  1  sticky starvation flag.
- mem_we  out  1  bank write enable.
- mem_addr  out  ADDR_W  bank address.
- mem_wdata  out  8  bank write data.
- mem_rdata  in  8  combinational bank read of `mem_addr`.
- addr_err  out  1  one-cycle pulse on an out-of-range access.

## Operation
FSM states: IDLE, GNT_I2C, GNT_CORE.

Arbitration:
- Eligible requesters are `i2c_req` and `core_req && !i2c_lock`.
- The requester granted in the current cycle is masked from the next decision, because its `req` is still high.
- With two eligible requesters, round-robin applies: the one not equal to `last_winner` wins. `last_winner` resets to CORE, so I2C wins the first tie.
- The winner selects the next state (GNT_I2C or GNT_CORE). With no eligible requester, the next state is IDLE.

In a GNT_x state:
- `x_gnt` = 1.
- `mem_addr`/`mem_wdata` = the winner's request, registered on entry.
- `mem_we` = winner's `we` && addr < REGCOUNT.
- The bank commits the write at the end of the state.

Read data:
- `mem_rdata` is captured into `x_rdata` at the end of GNT_x; `x_rvalid` pulses the next cycle.
- `x_rvalid` also pulses for writes, as completion; `x_rdata` is then the pre-write value.

Out-of-range (addr ≥ REGCOUNT):
- Grant proceeds, `mem_we` = 0, `rdata` = 8'h00, and `addr_err` pulses together with `rvalid`.

Lock:
- `i2c_lock` rising while in GNT_CORE: the core access completes and is not aborted.
- While locked, `core_req` is only queued.

Starvation watchdog:
- An 8-bit saturating counter increments each cycle `core_req && !core_gnt && i2c_lock`.
- When the counter reaches MAX_WAIT, `core_starve` sets.
- Both the counter and `core_starve` clear on `core_gnt`.

## Timing
- Latency: `req` sampled high at edge N → `gnt` high in cycle N+1 → `rvalid`/`rdata` in cycle N+2.
- Throughput: one grant per cycle overall; the same requester can be granted at most every other cycle.
- Write-then-read ordering: an I2C write granted in N+1 followed by a core read granted in N+2 returns the new value.
- Reset (async, active-low): every output = 0, FSM = IDLE, `last_winner` = CORE, counter = 0.
- Reset asserted mid-grant drops the access with no write; the requester re-requests.
- Requesters keep `we`/`addr`/`wdata` stable from `req` rise until `gnt`.
- `req` still high the cycle after `gnt` counts as a new request.

## Structure
- Shared package `regbank_pkg`:
  - `arb_state_t` enum {IDLE, GNT_I2C, GNT_CORE}
  - `requester_t` enum {REQ_I2C, REQ_CORE}
  - localparam `DATA_W` = 8
- One sub-module, `starve_counter`: saturating counter with clear, threshold compare and sticky flag.
- The arbiter FSM, output registers and read-data capture live in `regbank_arbiter`.

## Test plan
- Reset, then `core_req` write addr 3 data 8'hA5 → `core_gnt` in cycle 1; `mem_we`=1, `mem_addr`=3, `mem_wdata`=A5; `core_rvalid` in cycle 2.
- Both requests high from reset and held, each re-requesting immediately → grants alternate I2C, CORE, I2C, CORE, …
- `i2c_lock`=1 with `core_req` held, MAX_WAIT=4 → no `core_gnt`; `core_starve`=1 after 4 waiting cycles. Drop the lock → `core_gnt` next cycle and `core_starve` clears.
- I2C write addr 7 = 8'h3C granted cycle 1, core read addr 7 granted cycle 2 → `core_rdata`=3C.
- Core write addr 40 (REGCOUNT=32) → `mem_we`=0; `addr_err` and `core_rvalid` pulse together; `core_rdata`=00.
- Reset asserted during GNT_I2C write → `mem_we` drops immediately, the register is unchanged, and all outputs are 0.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared types and constants for the register-bank arbiter and its helpers.
package regbank_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned STARVE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I2C,
    GNT_CORE
  } arb_state_t;

  typedef enum logic {
    REQ_I2C,
    REQ_CORE
  } requester_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating wait counter with synchronous clear and a sticky threshold flag.
module starve_counter
  import regbank_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic starve_o
);

  localparam logic [STARVE_W-1:0] Thresh = STARVE_W'(MAX_WAIT);

  logic [STARVE_W-1:0] count_q, count_d;
  logic                starve_q, starve_d;

  always_comb begin
    count_d  = count_q;
    starve_d = starve_q;
    if (clr_i) begin
      count_d  = '0;
      starve_d = 1'b0;
    end else if (inc_i) begin
      if (!(&count_q)) begin
        count_d = count_q + STARVE_W'(1);
      end
      // Only a waiting cycle can raise the flag, so MAX_WAIT = 0 does not fire spuriously.
      if (count_d >= Thresh) begin
        starve_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      starve_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  assign starve_o = starve_q;

endmodule

// File: rtl/regbank_arbiter.sv
// Two-port arbiter for the shared 8-bit register bank: I2C slave versus on-chip core,
// with I2C transaction locking, registered read-data return and a core starvation watchdog.
module regbank_arbiter
  import regbank_pkg::*;
#(
  parameter int unsigned REGCOUNT = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              i2c_req_i,
  input  logic              i2c_we_i,
  input  logic [ADDR_W-1:0] i2c_addr_i,
  input  logic [DATA_W-1:0] i2c_wdata_i,
  input  logic              i2c_lock_i,
  output logic              i2c_gnt_o,
  output logic              i2c_rvalid_o,
  output logic [DATA_W-1:0] i2c_rdata_o,

  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_starve_o,

  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              addr_err_o
);

  arb_state_t        state_q, state_d;
  requester_t        last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              in_range_q, in_range_d;

  logic              elig_i2c, elig_core;
  logic              i2c_gnt, core_gnt, busy;

  logic              i2c_rvalid_q, i2c_rvalid_d;
  logic              core_rvalid_q, core_rvalid_d;
  logic              addr_err_q, addr_err_d;
  logic [DATA_W-1:0] i2c_rdata_q, i2c_rdata_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] cap_data;

  // The side being granted this cycle still has req high, so it sits out the next decision.
  always_comb begin
    elig_i2c  = i2c_req_i && (state_q != GNT_I2C);
    elig_core = core_req_i && !i2c_lock_i && (state_q != GNT_CORE);

    state_d = IDLE;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;

    if (elig_i2c && (!elig_core || (last_q == REQ_CORE))) begin
      state_d = GNT_I2C;
      last_d  = REQ_I2C;
      addr_d  = i2c_addr_i;
      wdata_d = i2c_wdata_i;
      we_d    = i2c_we_i;
    end else if (elig_core) begin
      state_d = GNT_CORE;
      last_d  = REQ_CORE;
      addr_d  = core_addr_i;
      wdata_d = core_wdata_i;
      we_d    = core_we_i;
    end

    in_range_d = (32'(addr_d) < REGCOUNT);
  end

  always_comb begin
    i2c_gnt  = 1'b0;
    core_gnt = 1'b0;
    unique case (state_q)
      GNT_I2C:  i2c_gnt  = 1'b1;
      GNT_CORE: core_gnt = 1'b1;
      default:  ;
    endcase
    busy = i2c_gnt | core_gnt;
  end

  // Capture happens at the end of the grant cycle, before the bank commits any write.
  always_comb begin
    cap_data      = in_range_q ? mem_rdata_i : '0;
    i2c_rvalid_d  = i2c_gnt;
    core_rvalid_d = core_gnt;
    addr_err_d    = busy && !in_range_q;
    i2c_rdata_d   = i2c_gnt ? cap_data : i2c_rdata_q;
    core_rdata_d  = core_gnt ? cap_data : core_rdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= REQ_CORE;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      in_range_q    <= 1'b0;
      i2c_rvalid_q  <= 1'b0;
      core_rvalid_q <= 1'b0;
      addr_err_q    <= 1'b0;
      i2c_rdata_q   <= '0;
      core_rdata_q  <= '0;
    end else begin
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      we_q          <= we_d;
      in_range_q    <= in_range_d;
      i2c_rvalid_q  <= i2c_rvalid_d;
      core_rvalid_q <= core_rvalid_d;
      addr_err_q    <= addr_err_d;
      i2c_rdata_q   <= i2c_rdata_d;
      core_rdata_q  <= core_rdata_d;
    end
  end

  starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .inc_i    (core_req_i && !core_gnt && i2c_lock_i),
    .clr_i    (core_gnt),
    .starve_o (core_starve_o)
  );

  assign i2c_gnt_o     = i2c_gnt;
  assign core_gnt_o    = core_gnt;
  assign i2c_rvalid_o  = i2c_rvalid_q;
  assign core_rvalid_o = core_rvalid_q;
  assign i2c_rdata_o   = i2c_rdata_q;
  assign core_rdata_o  = core_rdata_q;
  assign addr_err_o    = addr_err_q;
  assign mem_we_o      = busy && we_q && in_range_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Randomized and directed bench for regbank_arbiter against a cycle-level reference model.
module tb_regbank_arbiter;

  localparam int unsigned REGCOUNT = 32;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned MAX_WAIT = 4;

  logic              clk, rst_n;
  logic              i2c_req, i2c_we, i2c_lock;
  logic [ADDR_W-1:0] i2c_addr;
  logic [7:0]        i2c_wdata;
  logic              i2c_gnt, i2c_rvalid;
  logic [7:0]        i2c_rdata;
  logic              core_req, core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [7:0]        core_wdata;
  logic              core_gnt, core_rvalid, core_starve;
  logic [7:0]        core_rdata;
  logic              mem_we, addr_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, mem_rdata;

  logic [7:0] bank [REGCOUNT];
  logic       bank_init;

  int nvec, nerr;

  // Reference model state (expected outputs of the current cycle).
  logic [7:0] model_mem [REGCOUNT];
  int         m_gnt;   // 0 none, 1 i2c, 2 core
  int         m_last;  // 1 i2c, 2 core
  int         m_addr, m_wdata, m_we;
  int         m_rv_i, m_rv_c, m_rd_i, m_rd_c, m_err, m_cnt, m_starve;

  regbank_arbiter #(
    .REGCOUNT (REGCOUNT),
    .ADDR_W   (ADDR_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .i2c_req_i     (i2c_req),
    .i2c_we_i      (i2c_we),
    .i2c_addr_i    (i2c_addr),
    .i2c_wdata_i   (i2c_wdata),
    .i2c_lock_i    (i2c_lock),
    .i2c_gnt_o     (i2c_gnt),
    .i2c_rvalid_o  (i2c_rvalid),
    .i2c_rdata_o   (i2c_rdata),
    .core_req_i    (core_req),
    .core_we_i     (core_we),
    .core_addr_i   (core_addr),
    .core_wdata_i  (core_wdata),
    .core_gnt_o    (core_gnt),
    .core_rvalid_o (core_rvalid),
    .core_rdata_o  (core_rdata),
    .core_starve_o (core_starve),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata),
    .addr_err_o    (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < ADDR_W'(REGCOUNT)) ? bank[mem_addr[4:0]] : 8'hEE;

  always @(posedge clk) begin
    if (bank_init) begin
      for (int i = 0; i < REGCOUNT; i++) bank[i] <= 8'(i * 37 + 11);
    end else if (mem_we && (mem_addr < ADDR_W'(REGCOUNT))) begin
      bank[mem_addr[4:0]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gnt = 0; m_last = 2; m_addr = 0; m_wdata = 0; m_we = 0;
    m_rv_i = 0; m_rv_c = 0; m_rd_i = 0; m_rd_c = 0; m_err = 0;
    m_cnt = 0; m_starve = 0;
  endtask

  // Advance the model across one rising edge, using the inputs held before that edge.
  task automatic model_edge();
    int g_prev, win;
    bit inr, ei, ec;
    g_prev = m_gnt;
    inr    = (m_addr < REGCOUNT);
    m_rv_i = (g_prev == 1) ? 1 : 0;
    m_rv_c = (g_prev == 2) ? 1 : 0;
    m_err  = (g_prev != 0 && !inr) ? 1 : 0;
    if (g_prev == 1) m_rd_i = inr ? int'(model_mem[m_addr]) : 0;
    if (g_prev == 2) m_rd_c = inr ? int'(model_mem[m_addr]) : 0;
    if (g_prev != 0 && m_we != 0 && inr) model_mem[m_addr] = 8'(m_wdata);

    if (g_prev == 2) begin
      m_cnt = 0; m_starve = 0;
    end else if (core_req && i2c_lock) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt >= MAX_WAIT) m_starve = 1;
    end

    ei = i2c_req && (g_prev != 1);
    ec = core_req && !i2c_lock && (g_prev != 2);
    if (ei && ec) win = (m_last == 2) ? 1 : 2;
    else if (ei)  win = 1;
    else if (ec)  win = 2;
    else          win = 0;
    m_gnt = win;
    if (win == 1) begin
      m_last = 1; m_addr = int'(i2c_addr); m_wdata = int'(i2c_wdata); m_we = int'(i2c_we);
    end else if (win == 2) begin
      m_last = 2; m_addr = int'(core_addr); m_wdata = int'(core_wdata); m_we = int'(core_we);
    end
  endtask

  task automatic check_all();
    bit exp_we;
    exp_we = (m_gnt != 0) && (m_we != 0) && (m_addr < REGCOUNT);
    check("i2c_gnt", 32'(i2c_gnt), 32'(m_gnt == 1));
    check("core_gnt", 32'(core_gnt), 32'(m_gnt == 2));
    check("mem_we", 32'(mem_we), 32'(exp_we));
    if (m_gnt != 0) begin
      check("mem_addr", 32'(mem_addr), m_addr);
      check("mem_wdata", 32'(mem_wdata), m_wdata);
    end
    check("i2c_rvalid", 32'(i2c_rvalid), m_rv_i);
    check("core_rvalid", 32'(core_rvalid), m_rv_c);
    if (m_rv_i != 0) check("i2c_rdata", 32'(i2c_rdata), m_rd_i);
    if (m_rv_c != 0) check("core_rdata", 32'(core_rdata), m_rd_c);
    check("addr_err", 32'(addr_err), m_err);
    check("core_starve", 32'(core_starve), m_starve);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_i2c_gnt"}, 32'(i2c_gnt), 0);
    check({pfx, "_core_gnt"}, 32'(core_gnt), 0);
    check({pfx, "_i2c_rvalid"}, 32'(i2c_rvalid), 0);
    check({pfx, "_core_rvalid"}, 32'(core_rvalid), 0);
    check({pfx, "_i2c_rdata"}, 32'(i2c_rdata), 0);
    check({pfx, "_core_rdata"}, 32'(core_rdata), 0);
    check({pfx, "_starve"}, 32'(core_starve), 0);
    check({pfx, "_mem_we"}, 32'(mem_we), 0);
    check({pfx, "_mem_addr"}, 32'(mem_addr), 0);
    check({pfx, "_mem_wdata"}, 32'(mem_wdata), 0);
    check({pfx, "_addr_err"}, 32'(addr_err), 0);
  endtask

  task automatic idle_inputs();
    i2c_req = 1'b0; i2c_we = 1'b0; i2c_addr = '0; i2c_wdata = '0; i2c_lock = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_random();
    if (!i2c_req || m_gnt == 1) begin
      i2c_req = ($urandom_range(0, 2) != 0);
      if (i2c_req) begin
        i2c_we    = 1'($urandom);
        i2c_addr  = ADDR_W'($urandom_range(0, 39));
        i2c_wdata = 8'($urandom);
      end
    end
    if (!core_req || m_gnt == 2) begin
      core_req = ($urandom_range(0, 2) != 0);
      if (core_req) begin
        core_we    = 1'($urandom);
        core_addr  = ADDR_W'($urandom_range(0, 39));
        core_wdata = 8'($urandom);
      end
    end
    if ($urandom_range(0, 9) == 0) i2c_lock = ~i2c_lock;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    for (int i = 0; i < REGCOUNT; i++) model_mem[i] = 8'(i * 37 + 11);
    bank_init = 1'b1;
    do_reset();
    bank_init = 1'b0;

    // Core write 3 <= A5: grant in cycle 1, completion in cycle 2.
    core_req = 1'b1; core_we = 1'b1; core_addr = 6'd3; core_wdata = 8'hA5;
    step();
    check("wr3_gnt", 32'(core_gnt), 1);
    check("wr3_we", 32'(mem_we), 1);
    check("wr3_addr", 32'(mem_addr), 3);
    check("wr3_wdata", 32'(mem_wdata), 32'h A5);
    core_req = 1'b0;
    step();
    check("wr3_rvalid", 32'(core_rvalid), 1);
    step();
    check("wr3_bank", 32'(bank[3]), 32'h A5);

    // Both requesters held from reset: strict alternation starting with I2C.
    do_reset();
    i2c_req = 1'b1; i2c_addr = 6'd1;
    core_req = 1'b1; core_addr = 6'd2;
    for (int k = 0; k < 8; k++) begin
      step();
      check("alt_i2c", 32'(i2c_gnt), 32'(k % 2 == 0));
      check("alt_core", 32'(core_gnt), 32'(k % 2 == 1));
    end
    idle_inputs();
    step();
    step();

    // Lock holds the core off until the watchdog trips; unlocking grants and clears it.
    i2c_lock = 1'b1; core_req = 1'b1; core_we = 1'b0; core_addr = 6'd5;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("lock_gnt", 32'(core_gnt), 0);
      check("lock_starve", 32'(core_starve), 32'(k >= 4));
    end
    i2c_lock = 1'b0;
    step();
    check("unlock_gnt", 32'(core_gnt), 1);
    core_req = 1'b0;
    step();
    check("starve_clr", 32'(core_starve), 0);

    // I2C write 7 <= 3C then core read of 7 in the next cycle sees the new value.
    i2c_req = 1'b1; i2c_we = 1'b1; i2c_addr = 6'd7; i2c_wdata = 8'h3C;
    core_req = 1'b1; core_we = 1'b0; core_addr = 6'd7;
    step();
    check("wtr_i2c_gnt", 32'(i2c_gnt), 1);
    i2c_req = 1'b0;
    step();
    check("wtr_core_gnt", 32'(core_gnt), 1);
    core_req = 1'b0;
    step();
    check("wtr_rdata", 32'(core_rdata), 32'h 3C);

    // Out-of-range core write to 40.
    core_req = 1'b1; core_we = 1'b1; core_addr = 6'd40; core_wdata = 8'h77;
    step();
    check("oor_we", 32'(mem_we), 0);
    core_req = 1'b0;
    step();
    check("oor_err", 32'(addr_err), 1);
    check("oor_rvalid", 32'(core_rvalid), 1);
    check("oor_rdata", 32'(core_rdata), 0);

    idle_inputs();
    for (int n = 0; n < 1500; n++) begin
      drive_random();
      step();
    end
    idle_inputs();
    step();
    step();

    // Reset in the middle of an I2C write grant drops the write.
    i2c_req = 1'b1; i2c_we = 1'b1; i2c_addr = 6'd9; i2c_wdata = 8'h5A;
    step();
    check("mid_gnt", 32'(i2c_gnt), 1);
    #2;
    rst_n = 1'b0;
    i2c_req = 1'b0;
    #1;
    check_zero("mid");
    @(posedge clk);
    #1;
    check("mid_bank", 32'(bank[9]), 32'(model_mem[9]));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("mid_bank_after", 32'(bank[9]), 32'(model_mem[9]));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
